// File: rtl/ibus_cksyn_core.sv
// ibus_cksyn_core: measures the clk_ext period in clk cycles from a toggle level.
// Define IBUS_CKSYN_WATCHDOG_EN to add the loss watchdog and LOST state.
module ibus_cksyn_core #(
  parameter int SYNC_STAGES = 2,
  parameter int RATIO_W     = 8,
  parameter int TIMEOUT     = 200
) (
  input  logic               clk,
  input  logic               rst_a,
  input  logic               toggle,
  output logic               ext_edge,
  output logic [RATIO_W-1:0] ratio,
  output logic               ratio_vld,
  output logic               locked,
  output logic               lost
);

  localparam logic [RATIO_W-1:0] CNT_MAX = {RATIO_W{1'b1}};
  localparam logic [RATIO_W-1:0] CNT_ONE = {{(RATIO_W-1){1'b0}}, 1'b1};
`ifdef IBUS_CKSYN_WATCHDOG_EN
  localparam logic [RATIO_W-1:0] TO_LAST = RATIO_W'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEAS,
    ST_ACQ,
`ifdef IBUS_CKSYN_WATCHDOG_EN
    ST_LOST,
`endif
    ST_LOCK
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   tog_s;
  logic                   tog_d_q, tog_d_d;
  logic [RATIO_W-1:0]     cnt_q, cnt_d;
  logic [RATIO_W-1:0]     ratio_q, ratio_d;
  logic                   vld_q, vld_d;
  logic                   locked_q, locked_d;
  state_e                 state_q, state_d;
  logic [RATIO_W-1:0]     meas;
  logic [RATIO_W-1:0]     diff;
  logic                   close;
`ifdef IBUS_CKSYN_WATCHDOG_EN
  logic                   lost_q, lost_d;
  logic                   timeout;
`endif

  assign tog_s    = sync_q[SYNC_STAGES-1];
  assign ext_edge = tog_s ^ tog_d_q;

  // meas doubles as the saturating increment of the counter
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], toggle};
    tog_d_d = tog_s;
    meas    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    cnt_d   = ext_edge ? '0 : meas;
    diff    = (meas >= ratio_q) ? meas - ratio_q : ratio_q - meas;
    close   = (diff <= CNT_ONE) && (meas != CNT_MAX);
  end

  always_comb begin
    state_d = state_q;
    ratio_d = ratio_q;
    vld_d   = vld_q;
    unique case (state_q)
      ST_IDLE: if (ext_edge) state_d = ST_MEAS;
      ST_MEAS: begin
        if (ext_edge) begin
          state_d = ST_ACQ;
          ratio_d = meas;
          vld_d   = 1'b1;
        end
      end
      ST_ACQ: begin
        if (ext_edge) begin
          ratio_d = meas;
          if (close) state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (ext_edge) begin
          ratio_d = meas;
          if (!close) state_d = ST_ACQ;
        end
      end
`ifdef IBUS_CKSYN_WATCHDOG_EN
      ST_LOST: if (ext_edge) state_d = ST_MEAS;
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef IBUS_CKSYN_WATCHDOG_EN
    // an edge on the timeout cycle wins, so only edge-free cycles can expire
    timeout = !ext_edge && (cnt_q == TO_LAST) &&
              (state_q == ST_MEAS || state_q == ST_ACQ ||
               state_q == ST_LOCK);
    if (timeout) begin
      state_d = ST_LOST;
      vld_d   = 1'b0;
    end
    lost_d = (state_d == ST_LOST);
`endif
    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      sync_q   <= '0;
      tog_d_q  <= 1'b0;
      cnt_q    <= '0;
      ratio_q  <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      state_q  <= ST_IDLE;
`ifdef IBUS_CKSYN_WATCHDOG_EN
      lost_q   <= 1'b0;
`endif
    end else begin
      sync_q   <= sync_d;
      tog_d_q  <= tog_d_d;
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      vld_q    <= vld_d;
      locked_q <= locked_d;
      state_q  <= state_d;
`ifdef IBUS_CKSYN_WATCHDOG_EN
      lost_q   <= lost_d;
`endif
    end
  end

  assign ratio     = ratio_q;
  assign ratio_vld = vld_q;
  assign locked    = locked_q;
`ifdef IBUS_CKSYN_WATCHDOG_EN
  assign lost      = lost_q;
`else
  assign lost      = 1'b0;
`endif

endmodule

// File: tb/tb_ibus_cksyn_core.sv
// tb_ibus_cksyn_core: directed toggle patterns checked against an
// edge-timing model every cycle, plus literal expectations.
module tb_ibus_cksyn_core;

  localparam int S    = 2;
  localparam int W    = 8;
  localparam int T    = 200;
  localparam int MAXV = 255;
  localparam int HLEN = 4096;

  logic         clk = 1'b0;
  logic         rst_a;
  logic         toggle;
  logic         ext_edge;
  logic [W-1:0] ratio;
  logic         ratio_vld;
  logic         locked;
  logic         lost;

  int checks = 0;
  int errors = 0;

  ibus_cksyn_core #(
    .SYNC_STAGES(S),
    .RATIO_W    (W),
    .TIMEOUT    (T)
  ) dut (
    .clk      (clk),
    .rst_a    (rst_a),
    .toggle   (toggle),
    .ext_edge (ext_edge),
    .ratio    (ratio),
    .ratio_vld(ratio_vld),
    .locked   (locked),
    .lost     (lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: toggle level per cycle, with reset wiping older history.
  int hist [HLEN];
  int cyc      = 0;
  int last_rst = -100000;
  int last_ref = 0;
  int mode     = 0;  // 0 idle, 1 meas, 2 acq, 3 lock, 4 lost
  int e_ratio  = 0;
  int e_vld    = 0;
  int e_locked = 0;
  int e_lost   = 0;
  bit started  = 1'b0;

  function automatic int lvl(input int m);
    if (m < 0 || m >= HLEN || m <= last_rst) return 0;
    return hist[m];
  endfunction

  always @(negedge clk) begin
    int e_edge;
    int meas;
    int d;
    bit near;
    if (cyc < HLEN) hist[cyc] = int'(toggle);
    // the new level reaches the strobe S cycles after it is first sampled
    e_edge = lvl(cyc - S) ^ lvl(cyc - S - 1);
    if (started) begin
      chk("ext_edge", int'(ext_edge), e_edge);
      chk("ratio", int'(ratio), e_ratio);
      chk("ratio_vld", int'(ratio_vld), e_vld);
      chk("locked", int'(locked), e_locked);
      chk("lost", int'(lost), e_lost);
    end
    if (rst_a) begin
      mode     = 0;
      e_ratio  = 0;
      e_vld    = 0;
      last_ref = cyc;
      last_rst = cyc;
      started  = 1'b1;
    end else begin
      meas = cyc - last_ref;
      if (meas > MAXV) meas = MAXV;
      d = meas - e_ratio;
      if (d < 0) d = -d;
      near = (d <= 1) && (meas != MAXV);
      if (e_edge != 0) begin
        last_ref = cyc;
        case (mode)
          0: mode = 1;
          1: begin mode = 2; e_ratio = meas; e_vld = 1; end
          2: begin if (near) mode = 3; e_ratio = meas; end
          3: begin if (!near) mode = 2; e_ratio = meas; end
          default: mode = 1;
        endcase
      end
`ifdef IBUS_CKSYN_WATCHDOG_EN
      else if (mode >= 1 && mode <= 3 && cyc - last_ref == T) begin
        mode  = 4;
        e_vld = 0;
      end
`endif
    end
    e_locked = (mode == 3) ? 1 : 0;
    e_lost   = (mode == 4) ? 1 : 0;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int p);
    toggle = ~toggle;
    repeat (p) step();
  endtask

  initial begin
    int found;
    rst_a  = 1'b1;
    toggle = 1'b0;
    repeat (3) step();
    chk("rst_ratio", int'(ratio), 0);
    chk("rst_vld", int'(ratio_vld), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_lost", int'(lost), 0);
    chk("rst_edge", int'(ext_edge), 0);
    rst_a = 1'b0;
    repeat (5) step();

    // steady period of 4
    pulse(4);
    pulse(4);
    chk("lock2_vld", int'(ratio_vld), 1);
    chk("lock2_ratio", int'(ratio), 4);
    chk("lock2_locked", int'(locked), 0);
    pulse(4);
    chk("lock3_locked", int'(locked), 1);
    repeat (3) pulse(4);

    // jitter: each check sees the interval that ended with that flip
    pulse(5); chk("jit_a", int'(ratio), 4);
    pulse(4); chk("jit_b", int'(ratio), 5);
    pulse(5); chk("jit_c", int'(ratio), 4);
    pulse(4); chk("jit_d", int'(ratio), 5);
    chk("jit_locked", int'(locked), 1);

    // step 4 -> 9
    pulse(9);
    chk("step_pre", int'(locked), 1);
    pulse(9);
    chk("step_unlock", int'(locked), 0);
    chk("step_ratio", int'(ratio), 9);
    pulse(9);
    chk("step_relock", int'(locked), 1);

    // edge on exactly the timeout cycle
    pulse(T);
    pulse(4);
    chk("tie_ratio", int'(ratio), T);
    chk("tie_lost", int'(lost), 0);

    repeat (3) pulse(4);
    chk("relock", int'(locked), 1);

    // toggle stops
    toggle = ~toggle;
`ifdef IBUS_CKSYN_WATCHDOG_EN
    found = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (lost) begin
        found = i;
        break;
      end
    end
    // strobe after S, counter restart one later, then T cycles
    chk("lost_delay", found, S + 1 + T);
    chk("lost_vld", int'(ratio_vld), 0);
    chk("lost_locked", int'(locked), 0);
    pulse(4);
    chk("back_lost", int'(lost), 0);
    chk("back_vld", int'(ratio_vld), 0);
    chk("back_locked", int'(locked), 0);
`else
    repeat (260) step();
    chk("nowd_lost", int'(lost), 0);
    chk("nowd_locked", int'(locked), 1);
    chk("nowd_vld", int'(ratio_vld), 1);
    pulse(4);
    chk("nowd_sat", int'(ratio), MAXV);
    chk("nowd_unlock", int'(locked), 0);
`endif
    repeat (4) pulse(4);
    chk("pre_rst_locked", int'(locked), 1);

    // reset pulse while locked
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("mid_rst_ratio", int'(ratio), 0);
    chk("mid_rst_vld", int'(ratio_vld), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_lost", int'(lost), 0);
    chk("mid_rst_edge", int'(ext_edge), 0);
    pulse(4);
    pulse(4);
    chk("re2_locked", int'(locked), 0);
    chk("re2_vld", int'(ratio_vld), 1);
    pulse(4);
    chk("re3_locked", int'(locked), 1);
    chk("re3_ratio", int'(ratio), 4);
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibus_cksyn_core.md
IBUS_CKSYN_CORE -- requirements
Module: ibus_cksyn_core

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on toggle (legal range 2..4).
REQ-002 SHALL have parameter RATIO_W, default 8, the width of the interval counter and the ratio output.
REQ-003 SHALL have parameter TIMEOUT, default 200, the number of clk cycles without an edge before loss is declared (legal range 4..2^RATIO_W-1).
REQ-004 SHALL have port clk, input, 1 bit, the core clock, which is the only clock of the block.
REQ-005 SHALL have port rst_a, input, 1 bit, the reset, which is synchronous to clk and active-high.
REQ-006 SHALL have port toggle, input, 1 bit, the level from the clk_ext domain that inverts once per clk_ext rising edge; it is asynchronous to clk.
REQ-007 SHALL have port ext_edge, output, 1 bit, a one-clk strobe per synchronized toggle transition.
REQ-008 SHALL have port ratio, output, RATIO_W bits, the clk cycles between the last two edges.
REQ-009 SHALL have port ratio_vld, output, 1 bit, high when ratio holds a completed measurement.
REQ-010 SHALL have port locked, output, 1 bit, high when the interval is stable.
REQ-011 SHALL have port lost, output, 1 bit, high when the toggle has stopped.

Function
REQ-012 SHALL sample toggle through a SYNC_STAGES-deep flop chain; the last stage is tog_s, and tog_d_r is one more register of tog_s.
REQ-013 SHALL drive ext_edge = tog_s XOR tog_d_r, giving exactly one cycle high per toggle transition.
- First clk edge sampling the new toggle level: edge 0.
- ext_edge is high in the cycle following edge SYNC_STAGES-1.
REQ-014 SHALL keep an interval counter cnt_r that clears to 0 in the cycle after ext_edge, otherwise increments by 1 and saturates at 2^RATIO_W-1.
REQ-015 SHALL compute the new measurement on ext_edge as meas = cnt_r+1, saturated at 2^RATIO_W-1; edges at cycles t0 and t1 give meas = t1-t0.
REQ-016 SHALL load ratio with meas on every ext_edge in states MEAS, ACQ and LOCK, and hold ratio otherwise.
REQ-017 SHALL implement an FSM with states IDLE, MEAS, ACQ, LOCK and LOST.
REQ-018 SHALL, in IDLE, go to MEAS on ext_edge and ignore the counter.
REQ-019 SHALL, in MEAS, go to ACQ on ext_edge and set ratio_vld.
REQ-020 SHALL, in ACQ, go to LOCK on ext_edge when |meas-ratio| <= 1 and meas is not saturated, and otherwise stay in ACQ.
REQ-021 SHALL, in LOCK, go to ACQ on ext_edge when |meas-ratio| > 1 or meas is saturated, and otherwise stay in LOCK.
REQ-022 SHALL, in MEAS, ACQ or LOCK, go to LOST when cnt_r reaches TIMEOUT-1 with no ext_edge in that cycle.
REQ-023 SHALL, in LOST, go to MEAS on ext_edge.
REQ-024 SHALL let ext_edge take priority over timeout when both occur in the same cycle: no LOST, and normal edge handling applies.
REQ-025 SHALL drive locked = (state==LOCK) and lost = (state==LOST), both as registered state decodes.
REQ-026 SHALL clear ratio_vld on entry to LOST or IDLE; ratio itself holds its last value.
REQ-027 SHALL keep every output free of combinational paths from toggle.

Reset
REQ-028 SHALL, while rst_a=1 at a clk edge, set the sync chain, tog_d_r, cnt_r and ratio to 0, and the state to IDLE.
REQ-029 SHALL drive these values during reset: ext_edge=0, ratio=0, ratio_vld=0, locked=0, lost=0.
REQ-030 SHALL, on reset asserted mid-operation in any state, abandon the measurement in the same cycle; the first toggle transition after release counts as a fresh first edge.

Configuration
REQ-031 SHALL implement the loss watchdog only when macro IBUS_CKSYN_WATCHDOG_EN is defined.
- Defined: REQ-022/023 are active.
- Undefined: the LOST state and its logic are absent, lost is tied 0, cnt_r only saturates, and the FSM holds its state while no edges arrive.

Verification
REQ-032 SHALL cover steady lock: toggle flips every 4 clk -> ratio=4, ratio_vld=1 after the 2nd edge, locked=1 after the 3rd edge.
REQ-033 SHALL cover jitter tolerance: intervals 4,5,4,5 after lock -> locked stays 1 and ratio tracks 4/5.
REQ-034 SHALL cover a step change: interval changes from 4 to 9 while in LOCK -> locked=0 at that edge with ratio=9; locked=1 again after the next 9-cycle interval.
REQ-035 SHALL cover the watchdog: toggle stops in LOCK with TIMEOUT=200 -> lost=1 exactly 200 cycles after the last ext_edge; the next toggle gives lost=0, state MEAS, ratio_vld=0 (macro defined); lost is never 1 with the macro undefined.
REQ-036 SHALL cover the edge-versus-timeout tie: ext_edge lands on the cycle cnt_r=TIMEOUT-1 -> no LOST, and ratio=TIMEOUT.
REQ-037 SHALL cover reset mid-lock: rst_a pulsed for 1 cycle in LOCK -> all outputs 0 the next cycle, then lock reacquired after 3 edges.
